// File: rtl/pulse_stretcher.sv
// Stretches a one-cycle strobe into a PULSE_LEN-cycle level pulse followed by a
// GAP_LEN-cycle low gap. Define PULSE_STRETCHER_RETRIGGER_EN to let strobes during the pulse extend it.
module pulse_stretcher #(
    parameter int PULSE_LEN = 4,
    parameter int GAP_LEN   = 2
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic stb_i,
    output logic pulse_o,
    output logic busy_o,
    output logic drop_o
);

    localparam int MAX_LEN = (PULSE_LEN > GAP_LEN) ? PULSE_LEN : GAP_LEN;
    localparam int CNT_W   = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_LEN - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'(GAP_LEN - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        GAP    = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pend_q, pend_d;
    logic             drop_q, drop_d;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            pend_q  <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            drop_q  <= drop_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        drop_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (stb_i) begin
                    state_d = ACTIVE;
                    cnt_d   = PULSE_LOAD;
                end
            end
            ACTIVE: begin
`ifdef PULSE_STRETCHER_RETRIGGER_EN
                if (stb_i) begin
                    cnt_d = PULSE_LOAD;
                end else if (cnt_q == '0) begin
                    state_d = GAP;
                    cnt_d   = GAP_LOAD;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
`else
                // A strobe on the last pulse cycle lands in the gap, so it is queued rather than dropped.
                if (cnt_q == '0) begin
                    state_d = GAP;
                    cnt_d   = GAP_LOAD;
                    if (stb_i) begin
                        pend_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                    if (stb_i) begin
                        drop_d = 1'b1;
                    end
                end
`endif
            end
            GAP: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                    if (stb_i) begin
                        if (pend_q) begin
                            drop_d = 1'b1;
                        end else begin
                            pend_d = 1'b1;
                        end
                    end
                end else if (pend_q || stb_i) begin
                    state_d = ACTIVE;
                    cnt_d   = PULSE_LOAD;
                    pend_d  = 1'b0;
                    drop_d  = pend_q && stb_i;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                pend_d  = 1'b0;
            end
        endcase
    end

    assign pulse_o = (state_q == ACTIVE);
    assign busy_o  = (state_q != IDLE);
    assign drop_o  = drop_q;

endmodule
